prbs_gen: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random generator. It is the successor of the fixed 8-bit button-clocked PRBS and adds:
- configurable width and taps
- seed load
- run/single-step modes
- valid/ready output handshake
- all-zero lock-up recovery
- per-nibble hex digits for the seven-segment display path

It sits between the board button/switch inputs and the hex display decoders.

---
 rtl/prbs_pkg.sv | 44 ++++
 rtl/prbs_edge_det.sv | 22 ++
 rtl/prbs_gen.sv | 149 ++++++++++++++
 tb/tb_prbs_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator: FSM encoding, default tap masks
// and the Fibonacci LFSR advance function.
package prbs_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HOLD = 2'd3
    } prbs_state_t;

    localparam logic [3:0]  TAPS_W4  = 4'h3;
    localparam logic [7:0]  TAPS_W8  = 8'h1D;
    localparam logic [15:0] TAPS_W16 = 16'h002D;
    localparam logic [31:0] TAPS_W32 = 32'h0000_0057;

    // Widths without a listed mask fall back to the 8-bit mask; such builds
    // are expected to override TAPS explicitly.
    function automatic logic [MAX_WIDTH-1:0] default_taps(input int width);
        case (width)
            4:       return {28'd0, TAPS_W4};
            16:      return {16'd0, TAPS_W16};
            32:      return TAPS_W32;
            default: return {24'd0, TAPS_W8};
        endcase
    endfunction

    // Right shift, feedback enters at bit width-1; inputs must be zero-extended.
    function automatic logic [MAX_WIDTH-1:0] lfsr_next(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps,
        input int                   width
    );
        logic [MAX_WIDTH-1:0] nxt;
        logic                 fb;
        fb  = ^(state & taps);
        nxt = state >> 1;
        nxt[width-1] = fb;
        return nxt;
    endfunction

endpackage

// File: rtl/prbs_edge_det.sv
// Synchronous rising-edge detector used to turn a held step button into a
// single request.
module prbs_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_reg <= 1'b0;
        end else begin
            din_reg <= din;
        end
    end

    assign rise = din & ~din_reg;

endmodule

// File: rtl/prbs_gen.sv
// Parametrised Fibonacci LFSR generator with run/step control, valid/ready
// output, lock-up recovery and hex digits. Optional macro: PRBS_PERIOD_CNT_EN.
module prbs_gen
    import prbs_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               NDIG  = WIDTH / 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              load,
    input  logic [WIDTH-1:0]  seed_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  prbs_out,
    output logic [4*NDIG-1:0] hex_out,
    output logic              lockup,
    output logic [1:0]        state_o
`ifdef PRBS_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0]  period_o,
    output logic              period_vld
`endif
);

    prbs_state_t      state_reg;
    logic [WIDTH-1:0] lfsr_reg;
    logic [WIDTH-1:0] prbs_reg;
    logic             out_valid_reg;
    logic             lockup_reg;
    logic             step_rise;
    logic             advance;
    logic [WIDTH-1:0] adv_word;

    prbs_edge_det u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (step),
        .rise (step_rise)
    );

    // An all-zero register would never leave zero, so it restarts from SEED.
    always_comb begin
        adv_word = WIDTH'(lfsr_next(MAX_WIDTH'(lfsr_reg), MAX_WIDTH'(TAPS), WIDTH));
        if (lfsr_reg == '0) begin
            adv_word = SEED;
        end
    end

    assign advance = ((state_reg == RUN) || (state_reg == STEP))
                     && (!out_valid_reg || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            lfsr_reg      <= SEED;
            prbs_reg      <= SEED;
            out_valid_reg <= 1'b0;
            lockup_reg    <= 1'b0;
        end else if (load) begin
            lfsr_reg      <= seed_in;
            prbs_reg      <= seed_in;
            out_valid_reg <= 1'b1;
            if (seed_in == '0) begin
                lockup_reg <= 1'b1;
            end
            if (state_reg == STEP) begin
                state_reg <= HOLD;
            end
        end else begin
            if (advance) begin
                lfsr_reg      <= adv_word;
                prbs_reg      <= adv_word;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (run) begin
                        state_reg <= RUN;
                    end else if (step_rise) begin
                        state_reg <= STEP;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_reg <= IDLE;
                    end
                end
                STEP: begin
                    if (advance) begin
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_valid_reg && out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign prbs_out  = prbs_reg;
    assign lockup    = lockup_reg;
    assign state_o   = state_reg;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_hex
            assign hex_out[4*gi +: 4] = prbs_reg[4*gi +: 4];
        end
    endgenerate

`ifdef PRBS_PERIOD_CNT_EN
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] last_seed_reg;

    // Counts advances since the last seed; reports when the seed reappears.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            last_seed_reg <= SEED;
            period_o      <= '0;
            period_vld    <= 1'b0;
        end else if (load) begin
            count_reg     <= '0;
            last_seed_reg <= seed_in;
            period_vld    <= 1'b0;
        end else if (advance) begin
            if (adv_word == last_seed_reg) begin
                period_o   <= count_reg + 1'b1;
                period_vld <= 1'b1;
                count_reg  <= '0;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_prbs_gen.sv
// Scoreboard bench for prbs_gen (default 8-bit build): directed phases push
// hand-computed words, a negedge monitor pops them on each accepted transfer.
module tb_prbs_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       step;
    logic       load;
    logic [7:0] seed_in;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] prbs_out;
    logic [7:0] hex_out;
    logic       lockup;
    logic [1:0] state_o;
`ifdef PRBS_PERIOD_CNT_EN
    logic [7:0] period_o;
    logic       period_vld;
`endif

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic       mon_en = 1'b1;
    logic [7:0] mon_exp;

    prbs_gen dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .step      (step),
        .load      (load),
        .seed_in   (seed_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .prbs_out  (prbs_out),
        .hex_out   (hex_out),
        .lockup    (lockup),
        .state_o   (state_o)
`ifdef PRBS_PERIOD_CNT_EN
        ,
        .period_o  (period_o),
        .period_vld(period_vld)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; load = 1'b0;
        seed_in = 8'h00; out_ready = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: a transfer happens at the posedge following a negedge where
    // valid and ready are both high.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'd0, prbs_out}, 32'hFFFF_FFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("word", {24'd0, prbs_out}, {24'd0, mon_exp});
                check("hex", {24'd0, hex_out}, {24'd0, mon_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        check("rst_prbs", {24'd0, prbs_out}, 32'h01);
        check("rst_hex", {24'd0, hex_out}, 32'h01);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_lockup", {31'd0, lockup}, 32'd0);
        check("rst_state", {30'd0, state_o}, 32'd0);

        // Free run with a ready consumer.
        foreach (exp_q[i]) exp_q.delete();
        exp_q.push_back(8'h80); exp_q.push_back(8'h40); exp_q.push_back(8'h20);
        exp_q.push_back(8'h10); exp_q.push_back(8'h88); exp_q.push_back(8'hC4);
        exp_q.push_back(8'hE2); exp_q.push_back(8'h71);
        out_ready = 1'b1; run = 1'b1;
        tick(1);
        check("run_state", {30'd0, state_o}, 32'd1);
        check("run_valid_before", {31'd0, out_valid}, 32'd0);
        tick(1);
        check("run_valid_first", {31'd0, out_valid}, 32'd1);
        tick(6);
        run = 1'b0;
        tick(3);
        check("run_idle", {30'd0, state_o}, 32'd0);
        check("run_valid_end", {31'd0, out_valid}, 32'd0);
        drain("run");

        // Single step with the button held for five cycles.
        do_reset();
        exp_q.push_back(8'h80);
        step = 1'b1;
        tick(1);
        check("step_state_step", {30'd0, state_o}, 32'd2);
        tick(1);
        check("step_state_hold", {30'd0, state_o}, 32'd3);
        check("step_word", {24'd0, prbs_out}, 32'h80);
        tick(3);
        check("step_once", {24'd0, prbs_out}, 32'h80);
        check("step_hold_again", {30'd0, state_o}, 32'd3);
        step = 1'b0; out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("step_idle", {30'd0, state_o}, 32'd0);
        check("step_valid_clr", {31'd0, out_valid}, 32'd0);
        drain("step");

        // Back-pressure freezes the word.
        do_reset();
        exp_q.push_back(8'h80); exp_q.push_back(8'h40); exp_q.push_back(8'h20);
        run = 1'b1;
        tick(2);
        tick(4);
        check("bp_frozen", {24'd0, prbs_out}, 32'h80);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick(1);
        check("bp_release", {24'd0, prbs_out}, 32'h40);
        run = 1'b0;
        tick(3);
        drain("bp");

        // Zero seed triggers lock-up recovery.
        do_reset();
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        out_ready = 1'b1; load = 1'b1; seed_in = 8'h00;
        tick(1);
        load = 1'b0;
        check("lock_flag", {31'd0, lockup}, 32'd1);
        check("lock_word", {24'd0, prbs_out}, 32'h00);
        run = 1'b1;
        tick(1);
        run = 1'b0;
        tick(1);
        check("lock_recover", {24'd0, prbs_out}, 32'h01);
        tick(3);
        check("lock_sticky", {31'd0, lockup}, 32'd1);
        drain("lock");
        do_reset();
        check("lock_rst_clear", {31'd0, lockup}, 32'd0);

        // Load beats a concurrent advance.
        exp_q.push_back(8'h80); exp_q.push_back(8'hA5);
        exp_q.push_back(8'h52); exp_q.push_back(8'hA9);
        out_ready = 1'b1; run = 1'b1;
        tick(2);
        load = 1'b1; seed_in = 8'hA5;
        tick(1);
        load = 1'b0;
        check("load_word", {24'd0, prbs_out}, 32'hA5);
        tick(1);
        check("load_next", {24'd0, prbs_out}, 32'h52);
        check("load_dig1", {28'd0, hex_out[7:4]}, 32'h5);
        check("load_dig0", {28'd0, hex_out[3:0]}, 32'h2);
        run = 1'b0;
        tick(3);
        drain("load");

        // Long free run, then reset in the middle of it.
        do_reset();
        mon_en = 1'b0;
        out_ready = 1'b1; run = 1'b1;
`ifdef PRBS_PERIOD_CNT_EN
        begin
            int n = 0;
            while (!period_vld && n < 400) begin
                tick(1);
                n++;
            end
            check("period_vld", {31'd0, period_vld}, 32'd1);
            check("period_len", {24'd0, period_o}, 32'd255);
        end
`else
        tick(20);
`endif
        rst = 1'b1;
        tick(1);
        check("midrst_prbs", {24'd0, prbs_out}, 32'h01);
        check("midrst_hex", {24'd0, hex_out}, 32'h01);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_state", {30'd0, state_o}, 32'd0);
`ifdef PRBS_PERIOD_CNT_EN
        check("midrst_pvld", {31'd0, period_vld}, 32'd0);
`endif
        rst = 1'b0; run = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
